// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding scoreboard.
package fwd_pkg;

  localparam int unsigned REG_AW         = 5;
  localparam int unsigned RDY_W          = 3;
  localparam int unsigned ALU_READY_SLOT = 2;
  localparam int unsigned SEL_REGFILE    = 0;

  // One in-flight instruction after decode.
  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic [REG_AW-1:0] rd;
    logic [RDY_W-1:0]  ready_slot;
  } slot_t;

  // First slot from which this producer's result can be forwarded.
  function automatic logic [RDY_W-1:0] ready_slot_of(input logic is_load,
                                                     input int unsigned load_slot);
    return is_load ? RDY_W'(load_slot) : RDY_W'(ALU_READY_SLOT);
  endfunction

endpackage

// File: rtl/fwd_scoreboard_slot_match.sv
// Per-operand priority match against the slot records.
// Reports the forward select for the operand's consumption point
// (ID-use: producer slot; EX-use: producer slot one stage later) and
// whether the youngest matching producer is not yet forwardable.
module fwd_slot_match
  import fwd_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned SELW  = $clog2(DEPTH + 1)
) (
  input  slot_t [DEPTH:1]    slots,
  input  logic  [REG_AW-1:0] addr,
  input  logic               use_id,
  output logic  [SELW-1:0]   sel,
  output logic               stall_req
);

  logic        found;
  int unsigned hit_k;
  int unsigned hit_rdy;

  // Youngest (lowest-numbered) matching producer decides select or stall.
  always_comb begin
    found     = 1'b0;
    hit_k     = 0;
    hit_rdy   = 0;
    sel       = SELW'(SEL_REGFILE);
    stall_req = 1'b0;
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      if (!found && slots[k].valid && slots[k].reg_write &&
          (slots[k].rd != '0) && (slots[k].rd == addr)) begin
        found   = 1'b1;
        hit_k   = k;
        hit_rdy = int'(slots[k].ready_slot);
      end
    end
    if (found) begin
      if (use_id) begin
        if (hit_k < hit_rdy) stall_req = 1'b1;
        else                 sel       = SELW'(hit_k);
      end else begin
        // By the EX cycle the producer will have advanced one slot.
        if (hit_k + 1 < hit_rdy)   stall_req = 1'b1;
        else if (hit_k + 1 > DEPTH) sel      = SELW'(SEL_REGFILE);
        else                        sel      = SELW'(hit_k + 1);
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding/stall scoreboard for an in-order pipeline.
// Tracks DEPTH post-decode slot records, resolves per-operand forwarding
// selects and a combined hazard stall.
// Optional macro FWD_SCOREBOARD_STATS_EN adds a saturating stall_count output.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int unsigned NSRC      = 4,
  parameter int unsigned DEPTH     = 3,
  parameter int unsigned LOAD_SLOT = 3,
  parameter int unsigned SELW      = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic                   id_reg_write,
  input  logic                   id_is_load,
  input  logic [REG_AW-1:0]      id_rd,
  input  logic [NSRC*REG_AW-1:0] src_addr,
  input  logic [NSRC-1:0]        src_use_id,
  input  logic [NSRC-1:0]        src_en,
  input  logic                   freeze,
  output logic                   stall,
  output logic [NSRC*SELW-1:0]   fwd_id_sel,
  output logic [NSRC*SELW-1:0]   fwd_ex_sel
`ifdef FWD_SCOREBOARD_STATS_EN
  ,
  output logic [31:0]            stall_count
`endif
);

  slot_t [DEPTH:1]      slots;
  slot_t                new_rec;
  logic  [SELW-1:0]     port_sel [NSRC];
  logic  [NSRC-1:0]     port_req;
  logic  [NSRC*SELW-1:0] ex_sel_next;

  genvar gp;
  generate
    for (gp = 0; gp < NSRC; gp++) begin : g_port
      fwd_slot_match #(
        .DEPTH (DEPTH),
        .SELW  (SELW)
      ) u_match (
        .slots     (slots),
        .addr      (src_addr[gp*REG_AW +: REG_AW]),
        .use_id    (src_use_id[gp]),
        .sel       (port_sel[gp]),
        .stall_req (port_req[gp])
      );
    end
  endgenerate

  // Route each port's select to its consumption point; inactive ports are silent.
  always_comb begin
    fwd_id_sel  = '0;
    ex_sel_next = '0;
    stall       = 1'b0;
    for (int unsigned p = 0; p < NSRC; p++) begin
      if (src_en[p]) begin
        stall = stall | port_req[p];
        if (src_use_id[p]) fwd_id_sel[p*SELW +: SELW]  = port_sel[p];
        else               ex_sel_next[p*SELW +: SELW] = port_sel[p];
      end
    end
  end

  // Record entering slot 1: the decode instruction, or a bubble when stalled.
  always_comb begin
    new_rec            = '0;
    new_rec.valid      = id_valid && !stall;
    new_rec.reg_write  = id_reg_write;
    new_rec.rd         = id_rd;
    new_rec.ready_slot = ready_slot_of(id_is_load, LOAD_SLOT);
  end

  // Slot shift register and registered EX-stage select; freeze holds both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slots      <= '0;
      fwd_ex_sel <= '0;
    end else if (!freeze) begin
      for (int unsigned k = 2; k <= DEPTH; k++) begin
        slots[k] <= slots[k-1];
      end
      slots[1]   <= new_rec;
      fwd_ex_sel <= stall ? '0 : ex_sel_next;
    end
  end

`ifdef FWD_SCOREBOARD_STATS_EN
  // Saturating count of cycles actually lost to hazard stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall && !freeze && (stall_count != '1)) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule
